// File: rtl/game_pkg.sv
// Shared types and constants for the guess-entry path: FSM state encoding and
// BCD digit limits.
package game_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int          NUM_DIGITS = 4;
  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
endpackage

// File: rtl/digit_entry_if.sv
// Board-side bundle for digit_entry: round control, switches, raw buttons in;
// the entered guess and result flags out.
interface digit_entry_if;
  logic        displayPhase;
  logic [15:0] randInt;
  logic [3:0]  sw;
  logic        btnEnter;
  logic        btnDelete;
  logic        btnSubmit;
  logic [15:0] userInput;
  logic [2:0]  digitCount;
  logic        inputReady;
  logic        correct;

  modport master (
    output displayPhase, randInt, sw, btnEnter, btnDelete, btnSubmit,
    input  userInput, digitCount, inputReady, correct
  );

  modport slave (
    input  displayPhase, randInt, sw, btnEnter, btnDelete, btnSubmit,
    output userInput, digitCount, inputReady, correct
  );
endinterface

// File: rtl/digit_entry_debounce.sv
// button_debounce: 2-flop synchronizer, consecutive-sample debounce counter and
// a registered one-cycle pulse on the accepted 0->1 transition.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);
  logic [1:0]  sync_q, sync_d;
  logic        stable_q, stable_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;

  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    // Any sample agreeing with the stable level restarts the run.
    if (sync_q[1] == stable_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      stable_d = sync_q[1];
      cnt_d    = 16'd0;
      pulse_d  = sync_q[1];
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= 16'd0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/digit_entry.sv
// Captures a 4-digit BCD guess from switches and debounced buttons, then flags
// whether it matches randInt. Define INPUT_TIMEOUT_EN for ENTRY auto-submit.
module digit_entry
  import game_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
  input  logic          fastClk,
  input  logic          rst,
  digit_entry_if.slave  io
);
  localparam logic [2:0] FULL = 3'(NUM_DIGITS);

  logic p_enter, p_delete, p_submit, any_pulse, timeout_hit;

  state_e      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        correct_q, correct_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(fastClk), .rst(rst), .btn_raw(io.btnEnter), .pulse(p_enter));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_delete (
    .clk(fastClk), .rst(rst), .btn_raw(io.btnDelete), .pulse(p_delete));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
    .clk(fastClk), .rst(rst), .btn_raw(io.btnSubmit), .pulse(p_submit));

  assign any_pulse = p_enter | p_delete | p_submit;

`ifdef INPUT_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  // Ignored pulses also count as activity and restart the idle window.
  always_comb begin
    idle_d = 32'd0;
    if (state_q == ENTRY && !io.displayPhase && !any_pulse)
      idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) idle_q <= 32'd0;
    else     idle_q <= idle_d;
  end

  assign timeout_hit = (state_q == ENTRY) && !io.displayPhase && !any_pulse &&
                       (idle_q == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= 16'h0000;
      cnt_q     <= 3'd0;
      ready_q   <= 1'b0;
      correct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      correct_q <= correct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!io.displayPhase) state_d = ENTRY;
      ENTRY: begin
        if (io.displayPhase)                state_d = IDLE;
        else if (p_submit && cnt_q == FULL) state_d = READY;
        else if (timeout_hit)               state_d = READY;
      end
      READY: if (io.displayPhase) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    correct_d = correct_q;
    case (state_q)
      ENTRY: begin
        if (io.displayPhase) begin
          buf_d = 16'h0000;
          cnt_d = 3'd0;
        end else if (p_submit) begin
          // Lower-priority pulses in a submit cycle are dropped even if submit is.
          if (cnt_q == FULL) begin
            ready_d   = 1'b1;
            correct_d = (buf_q == io.randInt);
          end
        end else if (p_delete) begin
          if (cnt_q != 3'd0) begin
            buf_d = {4'h0, buf_q[15:4]};
            cnt_d = cnt_q - 3'd1;
          end
        end else if (p_enter) begin
          if (io.sw <= BCD_MAX && cnt_q < FULL) begin
            buf_d = {buf_q[11:0], io.sw};
            cnt_d = cnt_q + 3'd1;
          end
        end else if (timeout_hit) begin
          ready_d   = 1'b1;
          correct_d = 1'b0;
        end
      end
      READY: begin
        if (io.displayPhase) begin
          buf_d     = 16'h0000;
          cnt_d     = 3'd0;
          ready_d   = 1'b0;
          correct_d = 1'b0;
        end
      end
      default: begin
        buf_d     = 16'h0000;
        cnt_d     = 3'd0;
        ready_d   = 1'b0;
        correct_d = 1'b0;
      end
    endcase
  end

  assign io.userInput  = buf_q;
  assign io.digitCount = cnt_q;
  assign io.inputReady = ready_q;
  assign io.correct    = correct_q;
endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with DEBOUNCE_CYCLES=4: a vector table for
// entry sequences plus hand-written latency, bounce, priority and reset cases.
module tb_digit_entry;
  localparam int D = 4;
  localparam logic [1:0] OP_NEW = 2'd0, OP_ENT = 2'd1, OP_DEL = 2'd2, OP_SUB = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  sw;
    logic [15:0] rnd;
    logic [15:0] exp_ui;
    logic [2:0]  exp_cnt;
    logic        exp_rdy;
    logic        exp_cor;
  } vec_t;

  logic fastClk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];

  digit_entry_if intf();

  digit_entry #(.DEBOUNCE_CYCLES(16'(D)), .TIMEOUT_CYCLES(32'd100)) dut (
    .fastClk(fastClk), .rst(rst), .io(intf.slave));

  always #5 fastClk = ~fastClk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic [15:0] ui, input logic [2:0] cnt,
                         input logic rdy, input logic cor);
    chk({name, ".userInput"},  intf.userInput, ui);
    chk({name, ".digitCount"}, 16'(intf.digitCount), 16'(cnt));
    chk({name, ".inputReady"}, 16'(intf.inputReady), 16'(rdy));
    chk({name, ".correct"},    16'(intf.correct), 16'(cor));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge fastClk);
    #1;
  endtask

  task automatic press(input logic [1:0] op);
    case (op)
      OP_ENT: intf.btnEnter  = 1'b1;
      OP_DEL: intf.btnDelete = 1'b1;
      default: intf.btnSubmit = 1'b1;
    endcase
    cyc(D + 5);
    intf.btnEnter = 1'b0; intf.btnDelete = 1'b0; intf.btnSubmit = 1'b0;
    cyc(D + 5);
  endtask

  task automatic new_round();
    intf.displayPhase = 1'b1;
    cyc(3);
    intf.displayPhase = 1'b0;
    cyc(3);
  endtask

  function automatic vec_t v(input logic [1:0] op, input logic [3:0] sw, input logic [15:0] rnd,
                             input logic [15:0] ui, input logic [2:0] cnt, input logic rdy,
                             input logic cor);
    vec_t r;
    r.op = op; r.sw = sw; r.rnd = rnd; r.exp_ui = ui; r.exp_cnt = cnt;
    r.exp_rdy = rdy; r.exp_cor = cor;
    return r;
  endfunction

  initial begin
    intf.displayPhase = 1'b1;
    intf.randInt = 16'h0000;
    intf.sw = 4'h0;
    intf.btnEnter = 1'b0; intf.btnDelete = 1'b0; intf.btnSubmit = 1'b0;

    // Full correct guess
    vecs.push_back(v(OP_NEW, 4'h0, 16'h1234, 16'h0000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h1, 16'h1234, 16'h0001, 3'd1, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h2, 16'h1234, 16'h0012, 3'd2, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h3, 16'h1234, 16'h0123, 3'd3, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h4, 16'h1234, 16'h1234, 3'd4, 1'b0, 1'b0));
    vecs.push_back(v(OP_SUB, 4'h0, 16'h1234, 16'h1234, 3'd4, 1'b1, 1'b1));
    // Overflow enter, delete, wrong guess, READY holds
    vecs.push_back(v(OP_NEW, 4'h0, 16'h5678, 16'h0000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h5, 16'h5678, 16'h0005, 3'd1, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h6, 16'h5678, 16'h0056, 3'd2, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h7, 16'h5678, 16'h0567, 3'd3, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h8, 16'h5678, 16'h5678, 3'd4, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h9, 16'h5678, 16'h5678, 3'd4, 1'b0, 1'b0));
    vecs.push_back(v(OP_DEL, 4'h0, 16'h5678, 16'h0567, 3'd3, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h9, 16'h5678, 16'h5679, 3'd4, 1'b0, 1'b0));
    vecs.push_back(v(OP_SUB, 4'h0, 16'h5678, 16'h5679, 3'd4, 1'b1, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h1, 16'h5679, 16'h5679, 3'd4, 1'b1, 1'b0));
    vecs.push_back(v(OP_DEL, 4'h0, 16'h5679, 16'h5679, 3'd4, 1'b1, 1'b0));
    // Ignored operations
    vecs.push_back(v(OP_NEW, 4'h0, 16'h0012, 16'h0000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'hB, 16'h0012, 16'h0000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(v(OP_DEL, 4'h0, 16'h0012, 16'h0000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h1, 16'h0012, 16'h0001, 3'd1, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h2, 16'h0012, 16'h0012, 3'd2, 1'b0, 1'b0));
    vecs.push_back(v(OP_SUB, 4'h0, 16'h0012, 16'h0012, 3'd2, 1'b0, 1'b0));
    vecs.push_back(v(OP_ENT, 4'h3, 16'h0012, 16'h0123, 3'd3, 1'b0, 1'b0));

    #2;
    chk_all("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk_all("idle", 16'h0000, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      intf.sw = vecs[i].sw;
      intf.randInt = vecs[i].rnd;
      if (vecs[i].op == OP_NEW) new_round();
      else press(vecs[i].op);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_ui, vecs[i].exp_cnt,
              vecs[i].exp_rdy, vecs[i].exp_cor);
    end

    // Latency: change appears exactly D+3 edges after the raw edge
    new_round();
    intf.sw = 4'h7;
    @(posedge fastClk); #1;
    intf.btnEnter = 1'b1;
    cyc(D + 2);
    chk("lat_before", 16'(intf.digitCount), 16'd0);
    cyc(1);
    chk("lat_at", 16'(intf.digitCount), 16'd1);
    chk("lat_ui", intf.userInput, 16'h0007);
    intf.btnEnter = 1'b0;
    cyc(D + 5);

    // Bounce then hold: exactly one digit
    intf.sw = 4'h3;
    for (int k = 0; k < 10; k++) begin
      intf.btnEnter = (k % 2 == 0);
      cyc(2);
    end
    chk("bounce_none", 16'(intf.digitCount), 16'd1);
    intf.btnEnter = 1'b1;
    cyc(10);
    chk("bounce_one", intf.userInput, 16'h0073);
    cyc(1000);
    chk("hold_cnt", 16'(intf.digitCount), 16'd2);
    intf.btnEnter = 1'b0;
    cyc(D + 5);

    // Abort mid-ENTRY
    intf.displayPhase = 1'b1;
    cyc(2);
    chk_all("abort", 16'h0000, 3'd0, 1'b0, 1'b0);
    intf.displayPhase = 1'b0;
    cyc(2);

    // Fill to 4 digits, then delete+submit together: submit wins
    intf.randInt = 16'h2468;
    for (int k = 0; k < 4; k++) begin
      intf.sw = 4'(2 * (k + 1));
      press(OP_ENT);
    end
    chk("fill", intf.userInput, 16'h2468);
    intf.btnDelete = 1'b1; intf.btnSubmit = 1'b1; intf.btnEnter = 1'b1;
    cyc(D + 5);
    intf.btnDelete = 1'b0; intf.btnSubmit = 1'b0; intf.btnEnter = 1'b0;
    cyc(D + 5);
    chk_all("prio", 16'h2468, 3'd4, 1'b1, 1'b1);
    intf.randInt = 16'h0000;
    cyc(3);
    chk("hold_correct", 16'(intf.correct), 16'd1);

    // Async reset in READY
    @(negedge fastClk);
    rst = 1'b1;
    #1;
    chk_all("rst_ready", 16'h0000, 3'd0, 1'b0, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

`ifdef INPUT_TIMEOUT_EN
    new_round();
    intf.randInt = 16'h0037;
    intf.sw = 4'h3; press(OP_ENT);
    intf.sw = 4'h7; press(OP_ENT);
    cyc(80);
    chk("to_early", 16'(intf.inputReady), 16'd0);
    cyc(30);
    chk_all("timeout", 16'h0037, 3'd2, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- Input-side counterpart of the 7-segment display driver.
- Captures the player's 4-digit BCD guess from switches and three push buttons.
- Produces `userInput[15:0]` and `inputReady` for the display, and a registered `correct` flag comparing the guess to `randInt`.
- Sits between board I/O and the display/game-control logic. Entry opens when `displayPhase` falls and closes on submit.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: stable-input cycles (at `fastClk`) required before a button level is accepted; must be ≥2.
- TIMEOUT_CYCLES, 32'd500000000: idle cycles in ENTRY before auto-submit; used only with `INPUT_TIMEOUT_EN`.

Ports:
- fastClk  input  1  system clock; the only clock
- rst  input  1  asynchronous, active-high reset
- displayPhase  input  1  high while the target number is shown; entry disabled
- randInt  input  16  target number, 4 BCD digits, MSD in [15:12]
- sw  input  4  digit value to enter
- btnEnter  input  1  raw button: append digit
- btnDelete  input  1  raw button: remove last digit
- btnSubmit  input  1  raw button: submit guess
- userInput  output  16  entered digits, right-aligned, MSD in [15:12]
- digitCount  output  3  digits entered, 0..4
- inputReady  output  1  guess submitted; result valid
- correct  output  1  registered compare result; valid while inputReady=1

Behaviour:
- Reset (async, immediate): `userInput`=0, `digitCount`=0, `inputReady`=0, `correct`=0, state=IDLE, debouncers cleared (stable level 0).
- Buttons:
  - 2-flop synchronizer, then debounce counter; the stable level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - A one-cycle pulse is generated on the stable 0→1 transition only. Holding a button yields exactly one pulse.
- Same-cycle pulses: priority submit > delete > enter; lower-priority pulses in that cycle are dropped.
- IDLE:
  - Outputs held clear: `userInput`=0, `digitCount`=0, `inputReady`=0, `correct`=0. Button pulses are ignored.
  - `displayPhase`=0 → ENTRY next cycle.
- ENTRY:
  - Enter with `sw`≤9 and `digitCount`<4: `userInput` ← {userInput[11:0], sw}; `digitCount`+1.
  - Enter with `sw`>9, or with `digitCount`=4: ignored, no state change.
  - Delete with `digitCount`>0: `userInput` ← {4'h0, userInput[15:4]}; `digitCount`−1. With `digitCount`=0: ignored.
  - Submit with `digitCount`=4: next cycle `inputReady`=1 and `correct` = (`userInput`==`randInt`), sampled in the submit cycle; → READY.
  - Submit with `digitCount`<4: ignored.
  - `displayPhase`=1: abort to IDLE next cycle; buffer cleared. This takes priority over any button pulse in the same cycle.
- READY:
  - `userInput`, `inputReady`=1 and `correct` are held stable. Button pulses are ignored; later `randInt` changes do not alter `correct`.
  - `displayPhase`=1 → IDLE next cycle (new round).
- Latency: a button press is reflected in outputs DEBOUNCE_CYCLES+3 cycles after the raw edge (2 sync + counter + register).
- Reset mid-entry or mid-READY returns to IDLE immediately with all outputs cleared.

Optional Feature:
- `INPUT_TIMEOUT_EN` defined:
  - A 32-bit idle counter runs in ENTRY and resets on any accepted or ignored button pulse.
  - When it reaches TIMEOUT_CYCLES−1: → READY with `inputReady`=1 and `correct`=0, whatever `digitCount` is; `userInput` keeps its partial contents.
  - The counter is cleared in IDLE/READY and on reset.
- Not defined: no counter is built and ENTRY waits indefinitely.

Decomposition:
- Shared package `game_pkg`:
  - state enum: IDLE=2'd0, ENTRY=2'd1, READY=2'd2
  - NUM_DIGITS=4, BCD_MAX=4'd9, DIGIT_W=4
- Sub-module `button_debounce` (synchronizer, debounce counter and rising-edge pulse), instantiated three times.
- FSM, shift buffer and comparator live in `digit_entry`.

Test Plan:
- DEBOUNCE_CYCLES=4. Enter `sw`=1,2,3,4 then submit with `randInt`=16'h1234 → `userInput`=16'h1234, `digitCount`=4, `inputReady`=1, `correct`=1.
- Enter 5,6,7,8; a 5th enter with `sw`=9; delete; enter 9; submit with `randInt`=16'h5678 → 5th enter ignored; after delete `userInput`=16'h0567; final `userInput`=16'h5679, `correct`=0.
- Enter with `sw`=4'hB, delete at `digitCount`=0, submit at `digitCount`=2 → all ignored; state stays ENTRY; `inputReady`=0.
- Bouncy `btnEnter` (toggling every 2 cycles for 20 cycles, then held high 10 cycles) → exactly one digit appended; holding high for 1000 cycles adds no more.
- Enter and submit pulses in the same cycle with `digitCount`=4 → submit wins and no digit is appended. Raise `displayPhase` mid-ENTRY → IDLE with `userInput`=0. Assert `rst` in READY → all outputs 0 immediately.
- With `INPUT_TIMEOUT_EN`, TIMEOUT_CYCLES=100, enter 2 digits then idle 100 cycles → `inputReady`=1, `correct`=0, `userInput`=16'h00xy holding the two digits.
